// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : MIPS memory-access stage with the MEM/WB pipeline register.
//            Issues a req/ack data-memory access for loads and stores, stalls
//            the pipeline until the access completes, places store data on
//            byte lanes and extracts/extends load data.
// Ports    : clk, reset                 clock, synchronous active-high reset
//            ExMem*_i                   instruction held in EX/MEM
//            Dmem*_o / Dmem*_i          data-memory request / response
//            MemStall_o                 combinational stall to upstream
//            MemWb*_o                   registered values for writeback
//            MisalignException_o        1-cycle pulse on a misaligned access
//            BusError_o                 1-cycle pulse on request timeout
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ExMemValid_i,
   input  logic [31:0] ExMemAluOutput_i,
   input  logic [31:0] ExMemWriteData_i,
   input  logic [4:0]  ExMemDestination_i,
   input  logic        ExMemWriteRegEnable_i,
   input  logic        ExMemMemRead_i,
   input  logic        ExMemMemWrite_i,
   input  logic [1:0]  ExMemMemSize_i,
   input  logic        ExMemLoadUnsigned_i,
   output logic        DmemReq_o,
   output logic        DmemWe_o,
   output logic [31:0] DmemAddr_o,
   output logic [3:0]  DmemByteEn_o,
   output logic [31:0] DmemWData_o,
   input  logic        DmemAck_i,
   input  logic [31:0] DmemRData_i,
   output logic        MemStall_o,
   output logic [31:0] MemWbAluOutput_o,
   output logic [31:0] MemWbMemoryReadData_o,
   output logic [4:0]  MemWbDestination_o,
   output logic        MemWbWriteRegEnable_o,
   output logic        MemWbwritebackRegCtrl_o,
   output logic        MisalignException_o,
   output logic        BusError_o
);

   localparam int              CW          = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]   C_CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [0:0]      S_IDLE      = 1'b0;
   localparam logic [0:0]      S_REQ       = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          req_q, req_d, we_q, we_d;
   logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   mw_alu_q, mw_alu_d, mw_rdata_q, mw_rdata_d;
   logic [4:0]    mw_dest_q, mw_dest_d;
   logic          mw_wre_q, mw_wre_d, mw_ctrl_q, mw_ctrl_d;
   logic          misal_q, misal_d, buserr_q, buserr_d;

   logic [1:0]    w_off;
   logic          w_memop, w_misal, w_timeout_hit;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata, w_load;
   logic [7:0]    w_lbyte;
   logic [15:0]   w_lhalf;

   assign w_off         = ExMemAluOutput_i[1:0];
   assign w_memop       = ExMemValid_i & (ExMemMemRead_i | ExMemMemWrite_i);
   assign w_misal       = ((ExMemMemSize_i == 2'b01) & w_off[0]) |
                          (ExMemMemSize_i[1] & (w_off != 2'b00));
   // A zero timeout disables the abort path entirely.
   assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == C_CNT_LAST);

   // Store lane placement; loads always read the whole word.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = ExMemWriteData_i;
      if (ExMemMemWrite_i) begin
         if (ExMemMemSize_i == 2'b00) begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{ExMemWriteData_i[7:0]}};
         end else if (ExMemMemSize_i == 2'b01) begin
            w_be    = w_off[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{ExMemWriteData_i[15:0]}};
         end
      end
   end

   // Load lane extraction; address and size are still held upstream at ack.
   always_comb begin
      w_lhalf = w_off[1] ? DmemRData_i[31:16] : DmemRData_i[15:0];
      case (w_off)
         2'b00:   w_lbyte = DmemRData_i[7:0];
         2'b01:   w_lbyte = DmemRData_i[15:8];
         2'b10:   w_lbyte = DmemRData_i[23:16];
         default: w_lbyte = DmemRData_i[31:24];
      endcase
      if (ExMemMemSize_i == 2'b00)
         w_load = {{24{~ExMemLoadUnsigned_i & w_lbyte[7]}}, w_lbyte};
      else if (ExMemMemSize_i == 2'b01)
         w_load = {{16{~ExMemLoadUnsigned_i & w_lhalf[15]}}, w_lhalf};
      else
         w_load = DmemRData_i;
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (state_q == S_IDLE) begin
         if (w_memop & ~w_misal) state_d = S_REQ;
      end else begin
         if (DmemAck_i | w_timeout_hit) state_d = S_IDLE;
      end
   end

   // FSM: outputs and datapath next values. MEM/WB defaults to a bubble.
   always_comb begin
      MemStall_o = 1'b0;
      cnt_d      = cnt_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      mw_alu_d   = 32'h0;
      mw_rdata_d = 32'h0;
      mw_dest_d  = 5'd0;
      mw_wre_d   = 1'b0;
      mw_ctrl_d  = 1'b0;
      misal_d    = 1'b0;
      buserr_d   = 1'b0;
      if (state_q == S_IDLE) begin
         if (!w_memop) begin
            mw_alu_d  = ExMemAluOutput_i;
            mw_dest_d = ExMemDestination_i;
            mw_wre_d  = ExMemValid_i & ExMemWriteRegEnable_i;
         end else if (w_misal) begin
            misal_d = 1'b1;
         end else begin
            MemStall_o = 1'b1;
            req_d      = 1'b1;
            we_d       = ExMemMemWrite_i;
            addr_d     = {ExMemAluOutput_i[31:2], 2'b00};
            be_d       = w_be;
            wdata_d    = w_wdata;
            cnt_d      = '0;
         end
      end else begin
         if (DmemAck_i) begin
            req_d     = 1'b0;
            cnt_d     = '0;
            mw_alu_d  = ExMemAluOutput_i;
            mw_dest_d = ExMemDestination_i;
            if (ExMemMemRead_i) begin
               mw_wre_d   = ExMemWriteRegEnable_i;
               mw_ctrl_d  = 1'b1;
               mw_rdata_d = w_load;
            end
         end else begin
            MemStall_o = 1'b1;
            if (w_timeout_hit) begin
               req_d    = 1'b0;
               cnt_d    = '0;
               buserr_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 32'h0;
         be_q       <= 4'h0;
         wdata_q    <= 32'h0;
         mw_alu_q   <= 32'h0;
         mw_rdata_q <= 32'h0;
         mw_dest_q  <= 5'd0;
         mw_wre_q   <= 1'b0;
         mw_ctrl_q  <= 1'b0;
         misal_q    <= 1'b0;
         buserr_q   <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         mw_alu_q   <= mw_alu_d;
         mw_rdata_q <= mw_rdata_d;
         mw_dest_q  <= mw_dest_d;
         mw_wre_q   <= mw_wre_d;
         mw_ctrl_q  <= mw_ctrl_d;
         misal_q    <= misal_d;
         buserr_q   <= buserr_d;
      end
   end

   assign DmemReq_o               = req_q;
   assign DmemWe_o                = we_q;
   assign DmemAddr_o              = addr_q;
   assign DmemByteEn_o            = be_q;
   assign DmemWData_o             = wdata_q;
   assign MemWbAluOutput_o        = mw_alu_q;
   assign MemWbMemoryReadData_o   = mw_rdata_q;
   assign MemWbDestination_o      = mw_dest_q;
   assign MemWbWriteRegEnable_o   = mw_wre_q;
   assign MemWbwritebackRegCtrl_o = mw_ctrl_q;
   assign MisalignException_o     = misal_q;
   assign BusError_o              = buserr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Self-checking bench for mem_access_stage against a lane-level
//            reference model of loads, stores, stalls and exceptions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        ExMemValid, ExMemWriteRegEnable, ExMemMemRead, ExMemMemWrite, ExMemLoadUnsigned;
   logic [31:0] ExMemAluOutput, ExMemWriteData;
   logic [4:0]  ExMemDestination;
   logic [1:0]  ExMemMemSize;
   logic        DmemReq, DmemWe, DmemAck, MemStall;
   logic [31:0] DmemAddr, DmemWData, DmemRData;
   logic [3:0]  DmemByteEn;
   logic [31:0] MemWbAluOutput, MemWbMemoryReadData;
   logic [4:0]  MemWbDestination;
   logic        MemWbWriteRegEnable, MemWbwritebackRegCtrl, MisalignException, BusError;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .ExMemValid_i(ExMemValid), .ExMemAluOutput_i(ExMemAluOutput),
      .ExMemWriteData_i(ExMemWriteData), .ExMemDestination_i(ExMemDestination),
      .ExMemWriteRegEnable_i(ExMemWriteRegEnable), .ExMemMemRead_i(ExMemMemRead),
      .ExMemMemWrite_i(ExMemMemWrite), .ExMemMemSize_i(ExMemMemSize),
      .ExMemLoadUnsigned_i(ExMemLoadUnsigned),
      .DmemReq_o(DmemReq), .DmemWe_o(DmemWe), .DmemAddr_o(DmemAddr),
      .DmemByteEn_o(DmemByteEn), .DmemWData_o(DmemWData),
      .DmemAck_i(DmemAck), .DmemRData_i(DmemRData),
      .MemStall_o(MemStall),
      .MemWbAluOutput_o(MemWbAluOutput), .MemWbMemoryReadData_o(MemWbMemoryReadData),
      .MemWbDestination_o(MemWbDestination), .MemWbWriteRegEnable_o(MemWbWriteRegEnable),
      .MemWbwritebackRegCtrl_o(MemWbwritebackRegCtrl),
      .MisalignException_o(MisalignException), .BusError_o(BusError)
   );

   // ---------------- reference model (byte-lane arithmetic) ----------------
   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit ref_misaligned(input logic [1:0] size, input logic [31:0] addr);
      return (addr % nbytes(size)) != 0;
   endfunction

   // A lane is enabled when it belongs to the same naturally aligned
   // access-sized chunk as the address.
   function automatic logic [3:0] ref_be(input bit wr, input logic [1:0] size, input logic [31:0] addr);
      logic [3:0] be;
      int nb;
      nb = nbytes(size);
      be = 4'hF;
      if (wr)
         for (int i = 0; i < 4; i++) be[i] = ((i / nb) == ((addr % 4) / nb));
      return be;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] d);
      logic [31:0] w;
      int nb;
      nb = nbytes(size);
      for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nb) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] size, input bit uns,
                                            input logic [31:0] addr, input logic [31:0] r);
      logic [31:0] v, mask;
      int nb, off, bits;
      nb   = nbytes(size);
      off  = ((addr % 4) / nb) * nb;
      bits = 8 * nb;
      v    = r >> (8 * off);
      if (nb < 4) begin
         mask = (32'h1 << bits) - 32'h1;
         v    = v & mask;
         if (!uns && v[bits-1]) v = v | ~mask;
      end
      return v;
   endfunction

   // ---------------- drive helpers (no checking) ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input bit valid, input bit rd, input bit wr, input logic [1:0] size,
                         input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] dest, input bit wre);
      ExMemValid          = valid;
      ExMemMemRead        = rd;
      ExMemMemWrite       = wr;
      ExMemMemSize        = size;
      ExMemLoadUnsigned   = uns;
      ExMemAluOutput      = addr;
      ExMemWriteData      = wdata;
      ExMemDestination    = dest;
      ExMemWriteRegEnable = wre;
   endtask

   task automatic clear_ex();
      set_ex(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 5'd0, 0);
   endtask

   // One instruction through the stage, called at posedge+1 and returning at
   // posedge+1 once the stage has moved on. delay = REQ cycles before ack.
   task automatic do_access(input string nm, input bit valid, input bit rd, input bit wr,
                            input logic [1:0] size, input bit uns, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] dest, input bit wre,
                            input int delay, input logic [31:0] rdata);
      bit memop, mis;
      int stalls;
      logic [3:0]  e_be;
      logic [31:0] e_addr, e_wd;
      set_ex(valid, rd, wr, size, uns, addr, wdata, dest, wre);
      memop  = valid && (rd || wr);
      mis    = ref_misaligned(size, addr);
      e_be   = ref_be(wr, size, addr);
      e_wd   = ref_wdata(size, wdata);
      e_addr = addr & ~32'h3;
      if (!memop) begin
         DmemAck = 1'($urandom % 2);   // stray ack outside REQ must be ignored
         @(negedge clk);
         checks++; if (MemStall !== 1'b0) begin errors++; $display("FAIL %s alu stall: got %b expected 0", nm, MemStall); end
         tick();
         DmemAck = 1'b0;
         checks++; if (MemWbAluOutput !== addr) begin errors++; $display("FAIL %s alu out: got %h expected %h", nm, MemWbAluOutput, addr); end
         checks++; if (MemWbDestination !== dest) begin errors++; $display("FAIL %s alu dest: got %0d expected %0d", nm, MemWbDestination, dest); end
         checks++; if (MemWbWriteRegEnable !== (valid && wre)) begin errors++; $display("FAIL %s alu we: got %b expected %b", nm, MemWbWriteRegEnable, valid && wre); end
         checks++; if (MemWbwritebackRegCtrl !== 1'b0 || MemWbMemoryReadData !== 32'h0) begin errors++; $display("FAIL %s alu ctrl/rdata: got %b/%h expected 0/0", nm, MemWbwritebackRegCtrl, MemWbMemoryReadData); end
         checks++; if (DmemReq !== 1'b0) begin errors++; $display("FAIL %s alu req: got %b expected 0", nm, DmemReq); end
      end else if (mis) begin
         @(negedge clk);
         checks++; if (MemStall !== 1'b0 || DmemReq !== 1'b0) begin errors++; $display("FAIL %s misal stall/req: got %b/%b expected 0/0", nm, MemStall, DmemReq); end
         tick();
         checks++; if (MisalignException !== 1'b1) begin errors++; $display("FAIL %s misal exc: got %b expected 1", nm, MisalignException); end
         checks++; if (MemWbWriteRegEnable !== 1'b0 || DmemReq !== 1'b0) begin errors++; $display("FAIL %s misal we/req: got %b/%b expected 0/0", nm, MemWbWriteRegEnable, DmemReq); end
         clear_ex();
         tick();
         checks++; if (MisalignException !== 1'b0) begin errors++; $display("FAIL %s misal pulse end: got %b expected 0", nm, MisalignException); end
      end else begin
         @(negedge clk);
         checks++; if (MemStall !== 1'b1) begin errors++; $display("FAIL %s issue stall: got %b expected 1", nm, MemStall); end
         stalls = 1;
         tick();
         checks++; if (MemWbWriteRegEnable !== 1'b0) begin errors++; $display("FAIL %s issue bubble we: got %b expected 0", nm, MemWbWriteRegEnable); end
         for (int k = 0; k <= delay; k++) begin
            DmemAck   = (k == delay);
            DmemRData = (k == delay) ? rdata : $urandom;
            @(negedge clk);
            checks++; if (DmemReq !== 1'b1 || DmemWe !== wr || DmemAddr !== e_addr || DmemByteEn !== e_be) begin
               errors++; $display("FAIL %s req[%0d]: got req=%b we=%b addr=%h be=%b expected 1 %b %h %b", nm, k, DmemReq, DmemWe, DmemAddr, DmemByteEn, wr, e_addr, e_be);
            end
            if (wr) begin
               checks++; if (DmemWData !== e_wd) begin errors++; $display("FAIL %s wdata[%0d]: got %h expected %h", nm, k, DmemWData, e_wd); end
            end
            if (MemStall === 1'b1) stalls++;
            tick();
         end
         DmemAck = 1'b0;
         checks++; if (stalls !== delay + 1) begin errors++; $display("FAIL %s stall cycles: got %0d expected %0d", nm, stalls, delay + 1); end
         checks++; if (DmemReq !== 1'b0) begin errors++; $display("FAIL %s req drop: got %b expected 0", nm, DmemReq); end
         checks++; if (MemWbAluOutput !== addr || MemWbDestination !== dest) begin errors++; $display("FAIL %s mw alu/dest: got %h/%0d expected %h/%0d", nm, MemWbAluOutput, MemWbDestination, addr, dest); end
         checks++; if (MemWbWriteRegEnable !== (rd && wre) || MemWbwritebackRegCtrl !== rd) begin errors++; $display("FAIL %s mw we/ctrl: got %b/%b expected %b/%b", nm, MemWbWriteRegEnable, MemWbwritebackRegCtrl, rd && wre, rd); end
         checks++; if (MemWbMemoryReadData !== (rd ? ref_load(size, uns, addr, rdata) : 32'h0)) begin errors++; $display("FAIL %s mw rdata: got %h expected %h", nm, MemWbMemoryReadData, rd ? ref_load(size, uns, addr, rdata) : 32'h0); end
         clear_ex();
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1; clear_ex(); DmemAck = 1'b0; DmemRData = 32'h0;
      tick(); tick();
      checks++; if ({DmemReq, DmemWe, DmemAddr, DmemByteEn, DmemWData} !== 70'h0) begin errors++; $display("FAIL reset dmem: got %b %b %h %b %h expected zeros", DmemReq, DmemWe, DmemAddr, DmemByteEn, DmemWData); end
      checks++; if ({MemWbAluOutput, MemWbMemoryReadData, MemWbDestination, MemWbWriteRegEnable, MemWbwritebackRegCtrl} !== 71'h0) begin errors++; $display("FAIL reset memwb: got %h %h %0d %b %b expected zeros", MemWbAluOutput, MemWbMemoryReadData, MemWbDestination, MemWbWriteRegEnable, MemWbwritebackRegCtrl); end
      checks++; if ({MisalignException, BusError, MemStall} !== 3'b000) begin errors++; $display("FAIL reset flags: got %b%b%b expected 000", MisalignException, BusError, MemStall); end
      reset = 1'b0;
   endtask

   task automatic test_alu_op();
      do_access("alu", 1, 0, 0, 2'd2, 0, 32'h1234, 32'h0, 5'd5, 1, 0, 32'h0);
   endtask

   task automatic test_load_byte();
      do_access("lb",  1, 1, 0, 2'd0, 0, 32'h103, 32'h0, 5'd7, 1, 0, 32'h80FFFFFF);
      do_access("lbu", 1, 1, 0, 2'd0, 1, 32'h103, 32'h0, 5'd8, 1, 0, 32'h80FFFFFF);
   endtask

   task automatic test_store_half();
      do_access("sh", 1, 0, 1, 2'd1, 0, 32'h202, 32'hABCD1234, 5'd9, 1, 0, 32'h0);
   endtask

   task automatic test_misalign();
      do_access("lw_mis", 1, 1, 0, 2'd2, 0, 32'h101, 32'h0, 5'd3, 1, 0, 32'h0);
      do_access("sh_mis", 1, 0, 1, 2'd1, 0, 32'h201, 32'h5555AAAA, 5'd3, 0, 0, 32'h0);
   endtask

   task automatic test_wait_states();
      do_access("lw_wait", 1, 1, 0, 2'd2, 0, 32'h400, 32'h0, 5'd12, 1, 3, 32'hCAFEBABE);
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         int kind;
         logic [1:0]  size;
         logic [31:0] addr;
         bit rd, wr, valid;
         kind  = $urandom % 4;
         size  = 2'($urandom % 4);
         addr  = $urandom;
         valid = (kind == 0) ? 1'($urandom % 2) : 1'b1;
         rd    = (kind == 1) || (kind == 3 && $urandom % 2 == 0);
         wr    = (kind == 2) || (kind == 3 && !rd);
         if (kind == 1 || kind == 2) addr = addr - (addr % nbytes(size));
         do_access($sformatf("rnd%0d", n), valid, rd, wr, size, 1'($urandom % 2), addr,
                   $urandom, 5'($urandom), 1'($urandom % 2), $urandom_range(0, 2), $urandom);
      end
   endtask

   task automatic test_timeout();
      int cyc;
      set_ex(1, 1, 0, 2'd2, 0, 32'h300, 32'h0, 5'd4, 1);
      DmemAck = 1'b0;
      tick();
      checks++; if (DmemReq !== 1'b1) begin errors++; $display("FAIL timeout issue: got %b expected 1", DmemReq); end
      cyc = 0;
      while (DmemReq === 1'b1 && cyc < 12) begin
         tick();
         cyc++;
      end
      clear_ex();
      checks++; if (cyc !== TO) begin errors++; $display("FAIL timeout req cycles: got %0d expected %0d", cyc, TO); end
      checks++; if (BusError !== 1'b1 || MemWbWriteRegEnable !== 1'b0) begin errors++; $display("FAIL timeout buserr/we: got %b/%b expected 1/0", BusError, MemWbWriteRegEnable); end
      tick();
      checks++; if (BusError !== 1'b0 || DmemReq !== 1'b0) begin errors++; $display("FAIL timeout pulse end: got %b/%b expected 0/0", BusError, DmemReq); end
   endtask

   task automatic test_reset_mid_req();
      set_ex(1, 0, 1, 2'd2, 0, 32'h500, 32'h11223344, 5'd6, 0);
      DmemAck = 1'b0;
      tick();
      checks++; if (DmemReq !== 1'b1) begin errors++; $display("FAIL rstreq issue: got %b expected 1", DmemReq); end
      tick();
      reset = 1'b1;
      clear_ex();
      tick();
      checks++; if (DmemReq !== 1'b0 || MemWbWriteRegEnable !== 1'b0 || BusError !== 1'b0) begin errors++; $display("FAIL rstreq abandon: got req=%b we=%b be=%b expected 0 0 0", DmemReq, MemWbWriteRegEnable, BusError); end
      reset = 1'b0;
      do_access("post_rst", 1, 0, 0, 2'd0, 0, 32'hBEEF, 32'h0, 5'd31, 1, 0, 32'h0);
   endtask

   initial begin
      test_reset();
      test_alu_op();
      test_load_byte();
      test_store_half();
      test_misalign();
      test_wait_states();
      test_random();
      test_timeout();
      test_reset_mid_req();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
`default_nettype wire
